// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with valid/ready handshake.
// A main output register plus one skid register absorb a cycle of back-pressure without loss.
module imm_ext_pipe #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHIFT_B = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int EXT_W = OUT_W - IN_W;

    generate
        if (IN_W < 2 || OUT_W < IN_W + SHIFT_B) begin : g_bad_params
            $error("imm_ext_pipe: need IN_W >= 2 and OUT_W >= IN_W + SHIFT_B");
        end
    endgenerate

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      mode);
        logic [OUT_W-1:0] sext;
        sext = OUT_W'($signed(imm));
        case (mode)
            2'b00:   extend = sext;
            2'b01:   extend = OUT_W'(imm);
            2'b10:   extend = OUT_W'(imm) << EXT_W;
            2'b11:   extend = sext << SHIFT_B;
            default: extend = {OUT_W{1'b0}};
        endcase
    endfunction

    logic             skid_valid_r;
    logic [OUT_W-1:0] skid_data_r;
    logic [TAG_W-1:0] skid_tag_r;

    logic [OUT_W-1:0] ext_s;
    logic             accept_s;
    logic             main_free_s;

    // in_ready depends only on stored skid state and reset, never on out_ready.
    assign in_ready = !skid_valid_r && !rst;

    // Extension and transfer qualifiers.
    always_comb begin
        ext_s       = extend(in_imm, in_mode);
        accept_s    = in_valid && in_ready;
        main_free_s = !out_valid || out_ready;
    end

    // Main/skid register update; skid has priority into main to keep FIFO order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= {OUT_W{1'b0}};
            out_tag      <= {TAG_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {OUT_W{1'b0}};
            skid_tag_r   <= {TAG_W{1'b0}};
        end else if (main_free_s) begin
            if (skid_valid_r) begin
                out_data     <= skid_data_r;
                out_tag      <= skid_tag_r;
                out_valid    <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_data  <= ext_s;
                out_tag   <= in_tag;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept_s) begin
            // Main is stalled: park the new item until main drains.
            skid_data_r  <= ext_s;
            skid_tag_r   <= in_tag;
            skid_valid_r <= 1'b1;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

endmodule
